// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream handshake between host source and program loader
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles header-prefixed byte stream into instruction writes, then runs the processor
module program_loader #(
  parameter int WORD_W     = 23,
  parameter int RUN_CYCLES = 10
) (
  input  logic                clk,
  input  logic                reset,
  program_loader_if.slave     byte_s,
  input  logic                abort,
  output logic                write,
  output logic [WORD_W-1:0]   program_in,
  output logic                start,
  output logic                busy,
  output logic                done,
  output logic [7:0]          word_cnt,
  output logic                fmt_err
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);
  // Bits of the third byte that fall beyond the word width.
  localparam logic [7:0] HI_MASK = 8'hFF << (WORD_W - 16);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        asm_q, asm_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               write_q, write_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  program_in_q, program_in_d;
  logic [7:0]         word_cnt_q, word_cnt_d;
  logic               fmt_err_q, fmt_err_d;
  logic               accept;
  logic [23:0]        word_full;

  assign byte_s.byte_ready = ((state_q == S_IDLE) || (state_q == S_RECV)) && !abort;
  assign accept            = byte_s.byte_valid && byte_s.byte_ready;
  assign word_full         = {byte_s.byte_data, asm_q};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    remaining_d  = remaining_q;
    run_cnt_d    = run_cnt_q;
    program_in_d = program_in_q;
    word_cnt_d   = word_cnt_q;
    fmt_err_d    = fmt_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_cnt_d = 8'd0;
          fmt_err_d  = 1'b0;
          idx_d      = 2'd0;
          if (byte_s.byte_data != 8'd0) begin
            state_d     = S_RECV;
            remaining_d = byte_s.byte_data;
          end else begin
            state_d   = S_RUN;
            run_cnt_d = '0;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          if (idx_q == 2'd2) begin
            state_d      = S_WRITE;
            idx_d        = 2'd0;
            program_in_d = word_full[WORD_W-1:0];
            fmt_err_d    = fmt_err_q | (|(byte_s.byte_data & HI_MASK));
          end else begin
            // Shift right so the first byte ends up in the low half.
            asm_d = {byte_s.byte_data, asm_q[15:8]};
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d  = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q > 8'd1) begin
          state_d = S_RECV;
        end else begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          state_d = S_IDLE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      idx_d        = 2'd0;
      remaining_d  = 8'd0;
      run_cnt_d    = '0;
      program_in_d = program_in_q;
      word_cnt_d   = word_cnt_q;
      fmt_err_d    = fmt_err_q;
    end

    write_d = (state_d == S_WRITE);
    start_d = (state_d == S_RUN);
    done_d  = start_d && (run_cnt_d == RUN_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      asm_q        <= 16'd0;
      remaining_q  <= 8'd0;
      run_cnt_q    <= '0;
      write_q      <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      program_in_q <= '0;
      word_cnt_q   <= 8'd0;
      fmt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      remaining_q  <= remaining_d;
      run_cnt_q    <= run_cnt_d;
      write_q      <= write_d;
      start_q      <= start_d;
      done_q       <= done_d;
      program_in_q <= program_in_d;
      word_cnt_q   <= word_cnt_d;
      fmt_err_q    <= fmt_err_d;
    end
  end

  assign write      = write_q;
  assign start      = start_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign program_in = program_in_q;
  assign word_cnt   = word_cnt_q;
  assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized stream stimulus checked every cycle against a load/run reference model
module tb_program_loader;
  localparam int W  = 23;
  localparam int RC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  program_loader_if bus ();
  logic         write, start, busy, done, fmt_err;
  logic [W-1:0] program_in;
  logic [7:0]   word_cnt;

  program_loader #(.WORD_W(W), .RUN_CYCLES(RC)) dut (
    .clk(clk), .reset(rst_n), .byte_s(bus.slave), .abort(abort),
    .write(write), .program_in(program_in), .start(start), .busy(busy),
    .done(done), .word_cnt(word_cnt), .fmt_err(fmt_err)
  );

  // Reference model: data bytes still owed by the load, bytes of the current
  // word, pending write strobe and remaining run-window cycles.
  int           m_bytes_left = 0;
  int           m_nb = 0;
  int           m_run_left = 0;
  int           m_wc = 0;
  bit           m_write = 1'b0;
  bit           m_ferr = 1'b0;
  logic [7:0]   m_cur [3];
  logic [W-1:0] m_prog = '0;

  function automatic bit m_ready();
    return !m_write && (m_run_left == 0) && !abort;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_bytes_left = 0; m_nb = 0; m_run_left = 0; m_wc = 0;
      m_write = 1'b0; m_ferr = 1'b0; m_prog = '0;
    end else if (abort) begin
      m_write = 1'b0; m_run_left = 0; m_bytes_left = 0; m_nb = 0;
    end else if (m_write) begin
      m_write = 1'b0;
      if (m_wc < 255) m_wc++;
      if (m_bytes_left == 0) m_run_left = RC;
    end else if (m_run_left > 0) begin
      m_run_left--;
    end else if (bus.byte_valid) begin
      if (m_bytes_left == 0) begin
        m_wc = 0; m_ferr = 1'b0; m_nb = 0;
        m_bytes_left = 3 * int'(bus.byte_data);
        if (bus.byte_data == 8'd0) m_run_left = RC;
      end else begin
        m_cur[m_nb] = bus.byte_data;
        m_nb++;
        m_bytes_left--;
        if (m_nb == 3) begin
          logic [23:0] full;
          full = {m_cur[2], m_cur[1], m_cur[0]};
          m_prog = full[W-1:0];
          if ((full >> W) != 0) m_ferr = 1'b1;
          m_write = 1'b1;
          m_nb = 0;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0, n_st = 0, n_dn = 0;
  logic [23:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    logic r;
    bit   ok;
    repeat ($urandom_range(maxgap, 0)) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      r = bus.byte_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    bus.byte_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic load(input int gap);
    send(8'(wq.size()), gap);
    foreach (wq[i]) begin
      send(wq[i][7:0], gap);
      send(wq[i][15:8], gap);
      send(wq[i][23:16], gap);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle_timeout", 32'(idle), 32'd1);
    tick();
  endtask

  initial begin
    int w0, s0, d0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    fork
      forever begin
        @(negedge clk);
        chk("byte_ready", 32'(bus.byte_ready), 32'(m_ready()));
        chk("write", 32'(write), 32'(m_write));
        chk("start", 32'(start), 32'(m_run_left > 0));
        chk("done", 32'(done), 32'(m_run_left == 1));
        chk("busy", 32'(busy), 32'(m_write || m_run_left > 0 || m_bytes_left > 0));
        chk("program_in", 32'(program_in), 32'(m_prog));
        chk("word_cnt", 32'(word_cnt), 32'(m_wc));
        chk("fmt_err", 32'(fmt_err), 32'(m_ferr));
        if (write) n_wr++;
        if (start) n_st++;
        if (done) n_dn++;
      end
      begin
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_program_in", 32'(program_in), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
        repeat (20) tick();
        chk("idle_no_write", 32'(n_wr), 32'd0);
        chk("idle_no_start", 32'(n_st), 32'd0);

        w0 = n_wr; s0 = n_st; d0 = n_dn;
        wq = '{24'h000001};
        load(0);
        wait_idle();
        chk("n1_program_in", 32'(program_in), 32'h000001);
        chk("n1_writes", 32'(n_wr - w0), 32'd1);
        chk("n1_starts", 32'(n_st - s0), 32'd10);
        chk("n1_dones", 32'(n_dn - d0), 32'd1);
        chk("n1_word_cnt", 32'(word_cnt), 32'd1);

        w0 = n_wr;
        wq = '{24'h123456, 24'h7FFFFF, 24'h000000};
        load(3);
        wait_idle();
        chk("n3_writes", 32'(n_wr - w0), 32'd3);
        chk("n3_word_cnt", 32'(word_cnt), 32'd3);
        chk("n3_fmt_err", 32'(fmt_err), 32'd0);

        wq = '{24'hFFFFFF};
        load(1);
        wait_idle();
        chk("ff_program_in", 32'(program_in), 32'h7FFFFF);
        chk("ff_fmt_err", 32'(fmt_err), 32'd1);
        send(8'd1, 0);
        chk("ff_fmt_err_clear", 32'(fmt_err), 32'd0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        wait_idle();

        w0 = n_wr;
        send(8'd1, 0); send(8'hAA, 0); send(8'hBB, 0);
        abort = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hCC;
        tick();
        abort = 1'b0;
        bus.byte_valid = 1'b0;
        tick();
        chk("abort_no_write", 32'(n_wr - w0), 32'd0);
        wq = '{24'h0CBBAA};
        load(0);
        wait_idle();
        chk("abort_next_word", 32'(program_in), 32'h0CBBAA);
        chk("abort_writes", 32'(n_wr - w0), 32'd1);

        w0 = n_wr; s0 = n_st;
        send(8'd0, 0);
        wait_idle();
        chk("n0_writes", 32'(n_wr - w0), 32'd0);
        chk("n0_starts", 32'(n_st - s0), 32'd10);

        send(8'd0, 0);
        repeat (4) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_run_start", 32'(start), 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        repeat (6) begin
          int n;
          n = $urandom_range(5, 1);
          wq.delete();
          for (int i = 0; i < n; i++) wq.push_back(24'($urandom));
          w0 = n_wr;
          load(3);
          wait_idle();
          chk("rand_writes", 32'(n_wr - w0), 32'(n));
        end
        repeat (5) tick();
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
